// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage.
//   Owns the fetch PC, issues one instruction-memory request at a time and
//   presents returned instructions to ID through an output register backed
//   by a single skid entry. A redirect restarts the stream at npc and marks
//   any response still in flight as stale so it is dropped on arrival.
//
// Ports
//   clk, rstn         clock, asynchronous active-low reset
//   npc               next PC from next-PC logic (only source of pc updates)
//   redirect          flush; the fetch stream restarts at npc
//   id_ready          ID accepts the instruction presented this cycle
//   inst_req          memory request valid (only in REQ)
//   inst_addr         request address (= pc)
//   inst_addr_ok      memory accepted the request this cycle
//   inst_data_ok      response valid this cycle
//   inst_rdata        response instruction word
//   pc                current fetch PC
//   req_inst_success  inst_req & inst_addr_ok
//   if_valid/if_pc/if_inst  instruction presented to ID
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        id_ready,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pc,
    output logic        req_inst_success,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] req_pc;      // PC of the outstanding request
    logic [31:0] skid_pc;     // skid entry; valid exactly while in HOLD
    logic [31:0] skid_inst;
    logic        discard;     // outstanding response is stale
    logic        out_free;

    assign inst_req         = (state == REQ);
    assign inst_addr        = pc;
    assign req_inst_success = inst_req & inst_addr_ok;

    // Output register can take new data if empty or being consumed now.
    assign out_free = !if_valid || id_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_pc    <= 32'h0;
            skid_pc   <= 32'h0;
            skid_inst <= 32'h0;
            discard   <= 1'b0;
            if_valid  <= 1'b0;
            if_pc     <= 32'h0;
            if_inst   <= 32'h0;
        end else if (redirect) begin
            pc        <= npc;
            if_valid  <= 1'b0;
            skid_pc   <= 32'h0;
            skid_inst <= 32'h0;
            case (state)
                REQ: begin
                    // An address accepted this cycle belongs to the old stream.
                    if (inst_addr_ok) begin
                        state   <= WAIT;
                        discard <= 1'b1;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        state   <= REQ;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: state <= REQ;   // IDLE, HOLD
            endcase
        end else begin
            // Plain consumption; a load below in the same cycle overrides it.
            if (if_valid && id_ready)
                if_valid <= 1'b0;

            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (inst_addr_ok) begin
                        req_pc <= pc;
                        pc     <= npc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else if (out_free) begin
                            if_valid <= 1'b1;
                            if_pc    <= req_pc;
                            if_inst  <= inst_rdata;
                            state    <= REQ;
                        end else begin
                            skid_pc   <= req_pc;
                            skid_inst <= inst_rdata;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // if_valid is necessarily 1 here; refill it from the skid.
                    if (id_ready) begin
                        if_valid <= 1'b1;
                        if_pc    <= skid_pc;
                        if_inst  <= skid_inst;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table (reset, streaming, backpressure,
// redirects), async reset in WAIT, then randomized traffic against a
// transaction-level model of the fetch stream and a single-slot memory.
module tb_inst_fetch;

    localparam logic [31:0] A = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] npc;
    logic        redirect;
    logic        id_ready;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] pc;
    logic        req_inst_success;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.RESET_PC(A)) dut (
        .clk(clk), .rstn(rstn), .npc(npc), .redirect(redirect),
        .id_ready(id_ready), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .pc(pc), .req_inst_success(req_inst_success),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9e3779b9;
    endfunction

    typedef struct {
        logic        rd, rdy, aok, dok;
        logic [31:0] rdata, npc;
        logic        e_req, e_vld;
        logic [31:0] e_addr, e_ipc, e_inst, e_pc;
    } vec_t;

    function automatic vec_t v(input logic rd, rdy, aok, dok,
                               input logic [31:0] rdata, nxt,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_vld, input logic [31:0] e_ipc, e_inst, e_pc);
        vec_t r;
        r.rd = rd; r.rdy = rdy; r.aok = aok; r.dok = dok;
        r.rdata = rdata; r.npc = nxt;
        r.e_req = e_req; r.e_addr = e_addr; r.e_vld = e_vld;
        r.e_ipc = e_ipc; r.e_inst = e_inst; r.e_pc = e_pc;
        return r;
    endfunction

    localparam logic [31:0] I0 = 32'h02800401, I1 = 32'h02800802, I2 = 32'h02800c03,
                            I3 = 32'h02801004, I4 = 32'h02801405, I5 = 32'h02801806,
                            I6 = 32'h02801c07, S1 = 32'hdeadbeef, S2 = 32'hcafef00d;

    vec_t vecs[24];

    // random-phase model state
    logic [31:0] exp_fetch, exp_next, mem_addr;
    logic        mem_busy, accepted;
    int          mem_cnt, deliveries;

    initial begin
        //            rd rdy aok dok rdata npc       req addr     vld ipc      inst pc
        vecs[0]  = v(0, 1, 1, 0, 0,  A+4,     1, A,       0, 0,       0,  A);
        vecs[1]  = v(0, 1, 0, 1, I0, A+8,     0, A+4,     0, 0,       0,  A+4);
        vecs[2]  = v(0, 1, 1, 0, 0,  A+8,     1, A+4,     1, A,       I0, A+4);
        vecs[3]  = v(0, 1, 0, 1, I1, A+12,    0, A+8,     0, A,       I0, A+8);
        vecs[4]  = v(0, 1, 1, 0, 0,  A+12,    1, A+8,     1, A+4,     I1, A+8);
        vecs[5]  = v(0, 0, 0, 1, I2, A+16,    0, A+12,    0, A+4,     I1, A+12);
        vecs[6]  = v(0, 0, 1, 0, 0,  A+16,    1, A+12,    1, A+8,     I2, A+12);
        vecs[7]  = v(0, 0, 0, 1, I3, A+20,    0, A+16,    1, A+8,     I2, A+16);
        vecs[8]  = v(0, 0, 0, 0, 0,  A+20,    0, A+16,    1, A+8,     I2, A+16);
        vecs[9]  = v(0, 1, 0, 0, 0,  A+20,    0, A+16,    1, A+8,     I2, A+16);
        vecs[10] = v(0, 1, 1, 0, 0,  A+20,    1, A+16,    1, A+12,    I3, A+16);
        vecs[11] = v(0, 1, 0, 1, I4, A+24,    0, A+20,    0, A+12,    I3, A+20);
        vecs[12] = v(0, 1, 0, 0, 0,  A+24,    1, A+20,    1, A+16,    I4, A+20);
        vecs[13] = v(0, 1, 1, 0, 0,  A+24,    1, A+20,    0, A+16,    I4, A+20);
        vecs[14] = v(1, 1, 0, 0, 0,  A+32'h100, 0, A+24,  0, A+16,    I4, A+24);
        vecs[15] = v(0, 1, 0, 1, S1, A+32'h104, 0, A+32'h100, 0, A+16, I4, A+32'h100);
        vecs[16] = v(0, 1, 1, 0, 0,  A+32'h104, 1, A+32'h100, 0, A+16, I4, A+32'h100);
        vecs[17] = v(0, 1, 0, 1, I5, A+32'h108, 0, A+32'h104, 0, A+16, I4, A+32'h104);
        vecs[18] = v(1, 1, 1, 0, 0,  A+32'h200, 1, A+32'h104, 1, A+32'h100, I5, A+32'h104);
        vecs[19] = v(0, 1, 0, 1, S2, A+32'h204, 0, A+32'h200, 0, A+32'h100, I5, A+32'h200);
        vecs[20] = v(0, 1, 1, 0, 0,  A+32'h204, 1, A+32'h200, 0, A+32'h100, I5, A+32'h200);
        vecs[21] = v(0, 1, 0, 1, I6, A+32'h208, 0, A+32'h204, 0, A+32'h100, I5, A+32'h204);
        vecs[22] = v(0, 0, 0, 0, 0,  A+32'h208, 1, A+32'h204, 1, A+32'h200, I6, A+32'h204);
        vecs[23] = v(0, 0, 1, 0, 0,  A+32'h208, 1, A+32'h204, 1, A+32'h200, I6, A+32'h204);

        // ---------------- reset ----------------
        rstn = 1'b0; npc = 32'h0; redirect = 1'b0; id_ready = 1'b0;
        inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, A);
        chk("rst_req", {31'b0, inst_req}, 0);
        chk("rst_addr", inst_addr, A);
        chk("rst_vld", {31'b0, if_valid}, 0);
        chk("rst_ifpc", if_pc, 0);
        chk("rst_ifinst", if_inst, 0);
        chk("rst_success", {31'b0, req_inst_success}, 0);
        @(posedge clk); #1;
        rstn = 1'b1; inst_addr_ok = 1'b0;
        @(negedge clk);
        chk("idle_req", {31'b0, inst_req}, 0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            redirect = vecs[i].rd; id_ready = vecs[i].rdy;
            inst_addr_ok = vecs[i].aok; inst_data_ok = vecs[i].dok;
            inst_rdata = vecs[i].rdata; npc = vecs[i].npc;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'b0, inst_req}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("v%0d_addr", i), inst_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_success", i), {31'b0, req_inst_success},
                {31'b0, vecs[i].e_req & vecs[i].aok});
            chk($sformatf("v%0d_vld", i), {31'b0, if_valid}, {31'b0, vecs[i].e_vld});
            chk($sformatf("v%0d_ifpc", i), if_pc, vecs[i].e_ipc);
            chk($sformatf("v%0d_ifinst", i), if_inst, vecs[i].e_inst);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
        end

        // ---------------- async reset while in WAIT ----------------
        @(posedge clk); #1;
        redirect = 1'b0; id_ready = 1'b1; inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'hbad0bad0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("arst_pc", pc, A);
        chk("arst_req", {31'b0, inst_req}, 0);
        chk("arst_addr", inst_addr, A);
        chk("arst_vld", {31'b0, if_valid}, 0);
        chk("arst_ifpc", if_pc, 0);
        chk("arst_ifinst", if_inst, 0);
        @(posedge clk); #1;
        rstn = 1'b1;                      // data_ok still high in IDLE
        @(negedge clk);
        chk("arst_idle_req", {31'b0, inst_req}, 0);
        @(posedge clk); #1;
        inst_data_ok = 1'b0;
        @(negedge clk);
        chk("arst_first_req", {31'b0, inst_req}, 1);
        chk("arst_first_addr", inst_addr, A);
        chk("arst_vld_after", {31'b0, if_valid}, 0);

        // ---------------- randomized traffic ----------------
        exp_fetch = A; exp_next = A; mem_busy = 1'b0; mem_cnt = 0;
        mem_addr = 32'h0; deliveries = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            redirect     = ($urandom_range(0, 15) == 0);
            npc          = redirect ? A + 32'($urandom_range(0, 1023)) * 4 : exp_fetch + 4;
            id_ready     = ($urandom_range(0, 3) != 0);
            inst_addr_ok = $urandom_range(0, 1) == 1;
            if (mem_busy && mem_cnt == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = hash(mem_addr);
            end else begin
                inst_data_ok = 1'b0;
                inst_rdata   = $urandom;
            end
            @(negedge clk);
            accepted = inst_req && inst_addr_ok;
            chk("rnd_success", {31'b0, req_inst_success}, {31'b0, accepted});
            if (inst_req) begin
                chk("rnd_addr", inst_addr, exp_fetch);
                chk("rnd_single_outstanding", {31'b0, mem_busy}, 0);
            end
            if (if_valid && id_ready && !redirect) begin
                chk("rnd_ifpc", if_pc, exp_next);
                chk("rnd_ifinst", if_inst, hash(exp_next));
                exp_next = exp_next + 4;
                deliveries++;
            end
            // memory slot
            if (inst_data_ok) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (accepted) begin
                mem_busy = 1'b1;
                mem_addr = inst_addr;
                mem_cnt  = $urandom_range(0, 2);
            end
            // fetch stream
            if (redirect) begin
                exp_fetch = npc;
                exp_next  = npc;
            end else if (accepted) begin
                exp_fetch = exp_fetch + 4;
            end
        end
        chk("rnd_progress", {31'b0, deliveries > 100}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the pipelined core. It owns the architectural fetch PC register, loads it from the next-PC logic, and drives a single-outstanding request/response handshake to instruction memory. It buffers returned instructions (output register plus one skid entry) toward the ID stage and discards in-flight responses made stale by a redirect (exception entry, taken branch, jump, jirl).

## Interface
- RESET_PC, 32'h1c000000, PC value loaded on reset.
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  reset: asynchronous assert, active-low.
- npc  in  32  next PC from next-PC logic (sequential PC+4, branch/jump target, or EENTRY).
- redirect  in  1  flush: the fetch stream restarts at npc; highest priority.
- id_ready  in  1  ID accepts the instruction presented this cycle.
- inst_req  out  1  instruction memory request valid.
- inst_addr  out  32  request address; equals pc while inst_req=1.
- inst_addr_ok  in  1  memory accepted the request this cycle.
- inst_data_ok  in  1  response data valid this cycle.
- inst_rdata  in  32  response instruction word.
- pc  out  32  current fetch PC, fed back to next-PC logic.
- req_inst_success  out  1  inst_req & inst_addr_ok (combinational).
- if_valid  out  1  if_pc/if_inst hold a valid instruction for ID.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  presented instruction word.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. inst_req=1 only in REQ.
- IDLE: entered on reset; always moves to REQ the next cycle.
- REQ: inst_addr=pc. On inst_addr_ok: req_pc<=pc, pc<=npc, go to WAIT. pc and inst_addr stay stable until then.
- WAIT: one request is outstanding. On inst_data_ok:
  - if discard=1: drop the data, clear discard, go to REQ.
  - else if the output register is free (if_valid=0, or id_ready=1 this cycle): load if_inst<=inst_rdata, if_pc<=req_pc, if_valid<=1, go to REQ.
  - else: load the skid register {req_pc, inst_rdata}, go to HOLD.
- HOLD: no request. When id_ready=1: move skid into the output register (if_valid stays 1), go to REQ.
- Consumption: if_valid & id_ready with no new load clears if_valid.
- Redirect (overrides all of the above in the same cycle):
  - pc<=npc; if_valid<=0; skid cleared.
  - In REQ without inst_addr_ok: stay in REQ; the new address appears next cycle.
  - In REQ with inst_addr_ok: the accepted request is stale. Go to WAIT with discard<=1; pc<=npc, not an advance.
  - In WAIT without inst_data_ok: discard<=1, stay in WAIT.
  - In WAIT with inst_data_ok: drop the data, go to REQ.
  - In HOLD or IDLE: go to REQ.
- Stale data never reaches if_valid=1. At most one response is in flight, so a 1-bit discard suffices.
- All addresses are 32-bit. pc is never incremented internally; every pc update comes from npc.

## Timing
- Reset values: pc=RESET_PC, state IDLE, inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, discard=0, skid empty, req_inst_success=0.
- First inst_req=1 occurs in the first cycle after rstn deasserts (the cycle after IDLE).
- Best case (addr_ok in the request cycle, data_ok the next cycle): if_valid rises the cycle after data_ok. Throughput is one instruction per 2 cycles.
- Outputs if_* and pc are registered. inst_req and inst_addr come from state and pc only. req_inst_success is combinational.
- Async reset mid-transaction aborts everything. Memory-side cleanup is the memory's responsibility.

## Test plan
- Reset: hold rstn=0, then release. Required: pc=0x1c000000 and inst_req=0 during reset; inst_req=1 with inst_addr=0x1c000000 one cycle after release.
- Streaming: addr_ok immediate, data_ok next cycle, npc=pc+4, id_ready=1. Required: if_pc sequence 0x1c000000, 0x1c000004, 0x1c000008, each with its matching if_inst, one every 2 cycles.
- Backpressure: id_ready=0 while two instructions return. Required: second instruction goes to skid, FSM enters HOLD with inst_req=0. After id_ready=1, both delivered in order, then requests resume.
- Redirect in WAIT: redirect with npc=0x1c000100 before data_ok. Required: stale response dropped, if_valid stays 0, next inst_addr=0x1c000100.
- Redirect coincident with inst_addr_ok: redirect to 0x1c000200 in the same cycle as inst_addr_ok. Required: that response is dropped, then the request to 0x1c000200 issues.
- Async reset in WAIT: rstn=0 mid-cycle. Required: outputs return to reset values immediately, and a data_ok after release is ignored in IDLE.
